// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// codes, the request FSM states and the byte-lane enable patterns.
package dmem_responder_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_t;

   localparam int         LANES     = 4;
   localparam int         LANE_BITS = 8;
   localparam logic [3:0] BE_BYTE   = 4'b0001;
   localparam logic [3:0] BE_HALF   = 4'b0011;
   localparam logic [3:0] BE_WORD   = 4'b1111;

   // Stores have no unsigned variants, so funct3[2] is only legal on loads.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
   endfunction

endpackage

// File: rtl/dmem_sram.sv
// Word-addressed synchronous RAM built as one byte-wide array per lane so each
// lane maps onto its own block RAM with an independent write enable.
module dmem_sram
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic                        clk,
   input  logic                        en,
   input  logic [LANES-1:0]            be,
   input  logic [AW-1:0]               addr,
   input  logic [LANES*LANE_BITS-1:0]  wdata,
   output logic [LANES*LANE_BITS-1:0]  rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [LANE_BITS-1:0] mem [DEPTH_WORDS];
         logic [LANE_BITS-1:0] q_reg;

         always_ff @(posedge clk) begin
            if (en) begin
               if (be[gi]) begin
                  mem[addr] <= wdata[gi*LANE_BITS +: LANE_BITS];
               end
               q_reg <= mem[addr];
            end
         end

         assign rdata[gi*LANE_BITS +: LANE_BITS] = q_reg;
      end
   endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder: accepts one request, performs the
// RAM access in ACCESS, then holds the extended result in RESP until consumed.
`ifndef XLEN
`define XLEN 32
`endif

module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int XLEN        = `XLEN
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic            i_req_we,
   input  logic [2:0]      i_req_funct3,
   input  logic [XLEN-1:0] i_req_addr,
   input  logic [XLEN-1:0] i_req_wdata,
   output logic            o_rsp_valid,
   input  logic            i_rsp_ready,
   output logic [XLEN-1:0] o_rsp_rdata,
   output logic            o_rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_t            state_reg, state_next;
   logic              we_reg;
   logic [2:0]        funct3_reg;
   logic [XLEN-1:0]   addr_reg;
   logic [XLEN-1:0]   wdata_reg;
   logic              err_reg;

   logic              misaligned, out_of_range, access_err;
   logic [LANES-1:0]  be, ram_be;
   logic [XLEN-1:0]   wdata_lanes, ram_q, ram_shift, load_data;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_reg  <= ST_IDLE;
         we_reg     <= 1'b0;
         funct3_reg <= '0;
         addr_reg   <= '0;
         wdata_reg  <= '0;
         err_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_IDLE && i_req_valid) begin
            we_reg     <= i_req_we;
            funct3_reg <= i_req_funct3;
            addr_reg   <= i_req_addr;
            wdata_reg  <= i_req_wdata;
         end
         if (state_reg == ST_ACCESS) begin
            err_reg <= access_err;
         end
      end
   end

   always_comb begin
      misaligned = 1'b0;
      case (funct3_reg[1:0])
         2'b01:   misaligned = addr_reg[0];
         2'b10:   misaligned = (addr_reg[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
      out_of_range = (addr_reg[XLEN-1:2] >= (XLEN-2)'(DEPTH_WORDS));
      access_err   = f3_illegal(we_reg, funct3_reg) || misaligned || out_of_range;
   end

   // Store data is replicated across lanes so the byte enable alone picks the target.
   always_comb begin
      be          = BE_WORD;
      wdata_lanes = wdata_reg;
      case (funct3_reg[1:0])
         2'b00: begin
            be          = BE_BYTE << addr_reg[1:0];
            wdata_lanes = {4{wdata_reg[7:0]}};
         end
         2'b01: begin
            be          = BE_HALF << {addr_reg[1], 1'b0};
            wdata_lanes = {2{wdata_reg[15:0]}};
         end
         default: begin
            be          = BE_WORD;
            wdata_lanes = wdata_reg;
         end
      endcase
   end

   assign ram_be = (state_reg == ST_ACCESS && we_reg && !access_err) ? be : '0;

   dmem_sram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_sram (
      .clk   (i_clk),
      .en    (state_reg == ST_ACCESS),
      .be    (ram_be),
      .addr  (addr_reg[AW+1:2]),
      .wdata (wdata_lanes),
      .rdata (ram_q)
   );

   // ram_q is only refreshed in ACCESS, so it stays put for the whole RESP phase.
   always_comb begin
      ram_shift = ram_q >> {addr_reg[1:0], 3'b000};
      load_data = '0;
      case (funct3_reg)
         F3_B:    load_data = {{24{ram_shift[7]}}, ram_shift[7:0]};
         F3_BU:   load_data = {24'h0, ram_shift[7:0]};
         F3_H:    load_data = {{16{ram_shift[15]}}, ram_shift[15:0]};
         F3_HU:   load_data = {16'h0, ram_shift[15:0]};
         F3_W:    load_data = ram_q;
         default: load_data = '0;
      endcase
   end

   always_comb begin
      state_next  = state_reg;
      o_req_ready = 1'b0;
      o_rsp_valid = 1'b0;
      o_rsp_rdata = '0;
      o_rsp_err   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) state_next = ST_ACCESS;
         end
         ST_ACCESS: state_next = ST_RESP;
         ST_RESP: begin
            o_rsp_valid = 1'b1;
            o_rsp_err   = err_reg;
            o_rsp_rdata = (err_reg || we_reg) ? '0 : load_data;
            if (i_rsp_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-addressed
// reference memory; a monitor checks every presented response.
module tb_dmem_responder;

   localparam int DEPTH = 64;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        i_req_valid = 1'b0;
   logic        o_req_ready;
   logic        i_req_we = 1'b0;
   logic [2:0]  i_req_funct3 = 3'b000;
   logic [31:0] i_req_addr = 32'h0;
   logic [31:0] i_req_wdata = 32'h0;
   logic        o_rsp_valid;
   logic        i_rsp_ready = 1'b1;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_err;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .XLEN(32)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_req_we     (i_req_we),
      .i_req_funct3 (i_req_funct3),
      .i_req_addr   (i_req_addr),
      .i_req_wdata  (i_req_wdata),
      .o_rsp_valid  (o_rsp_valid),
      .i_rsp_ready  (i_rsp_ready),
      .o_rsp_rdata  (o_rsp_rdata),
      .o_rsp_err    (o_rsp_err)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

   always @(posedge i_clk) cycle <= cycle + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
      string       name;
   } exp_t;

   exp_t     sb[$];
   bit [7:0] model_mem [int];
   bit       in_rsp = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: byte-addressed memory, access size 1/2/4 from funct3[1:0].
   function automatic exp_t model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                  input bit [31:0] wdata);
      exp_t     e;
      int       size;
      bit       illegal, mis, range;
      bit [31:0] v;
      size    = 1 << f3[1:0];
      illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3 >= 4);
      mis     = (addr % size) != 0;
      range   = (addr / 4) >= DEPTH;
      e.err   = illegal || mis || range;
      e.rdata = 32'h0;
      e.due   = 0;
      e.name  = "";
      if (!e.err) begin
         if (we) begin
            for (int i = 0; i < size; i++) model_mem[int'(addr) + i] = wdata[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) begin
               if (model_mem.exists(int'(addr) + i))
                  v = v | (32'(model_mem[int'(addr) + i]) << (8*i));
            end
            if (f3 < 4 && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            e.rdata = v;
         end
      end
      return e;
   endfunction

   task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wdata, input bit track, input string name,
                         output int acc_cycle);
      exp_t e;
      int   n;
      n = 0;
      @(negedge i_clk);
      i_req_valid  = 1'b1;
      i_req_we     = we;
      i_req_funct3 = f3;
      i_req_addr   = addr;
      i_req_wdata  = wdata;
      while (!o_req_ready && n < 100) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_req_ready) begin
         checks++;
         errors++;
         $display("FAIL %s accept: req_ready stuck at 0, expected 1 within 100 cycles", name);
         i_req_valid = 1'b0;
         acc_cycle   = -1;
         return;
      end
      acc_cycle = cycle + 1;
      if (track) begin
         e      = model(we, f3, addr, wdata);
         e.due  = cycle + 2;
         e.name = name;
         sb.push_back(e);
      end
      @(posedge i_clk);
   endtask

   task automatic go_idle();
      @(negedge i_clk);
      i_req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      chk("drain_pending", 32'(sb.size()), 32'h0);
   endtask

   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         case (rdy_mode)
            0:       i_rsp_ready = 1'b1;
            1:       i_rsp_ready = 1'($urandom % 2);
            default: i_rsp_ready = 1'b0;
         endcase
      end
   end

   // Monitor: checks the head of the scoreboard on every cycle a response is shown.
   always @(negedge i_clk) begin
      if (o_rsp_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
         end else begin
            chk({sb[0].name, " rdata"}, o_rsp_rdata, sb[0].rdata);
            chk({sb[0].name, " err"}, 32'(o_rsp_err), 32'(sb[0].err));
            if (!in_rsp) chk({sb[0].name, " latency"}, 32'(cycle), 32'(sb[0].due));
            else         chk({sb[0].name, " req_ready_in_rsp"}, 32'(o_req_ready), 32'h0);
            in_rsp = 1'b1;
            if (i_rsp_ready) begin
               $display("rsp %-14s rdata=0x%08h err=%0b", sb[0].name, o_rsp_rdata, o_rsp_err);
               void'(sb.pop_front());
               in_rsp = 1'b0;
            end
         end
      end else begin
         in_rsp = 1'b0;
      end
   end

   int a0, a1, a2, a3, dummy;

   initial begin
      repeat (3) @(negedge i_clk);
      chk("reset rsp_valid", 32'(o_rsp_valid), 32'h0);
      chk("reset rsp_rdata", o_rsp_rdata, 32'h0);
      chk("reset rsp_err", 32'(o_rsp_err), 32'h0);
      i_rst = 1'b1;
      @(negedge i_clk);
      chk("post_reset req_ready", 32'(o_req_ready), 32'h1);

      rdy_mode = 1;
      for (int w = 0; w < 16; w++) do_req(1'b1, 3'b010, 32'(w*4), $urandom, 1'b1, "init_sw", dummy);
      do_req(1'b1, 3'b010, 32'(DEPTH*4 - 4), $urandom, 1'b1, "init_sw_top", dummy);
      go_idle();
      drain();

      rdy_mode = 0;
      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, "sw_10", dummy);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, "lw_10", dummy);
      do_req(1'b0, 3'b000, 32'h13, 32'h0, 1'b1, "lb_13", dummy);
      do_req(1'b0, 3'b100, 32'h13, 32'h0, 1'b1, "lbu_13", dummy);
      do_req(1'b0, 3'b001, 32'h12, 32'h0, 1'b1, "lh_12", dummy);
      do_req(1'b0, 3'b101, 32'h10, 32'h0, 1'b1, "lhu_10", dummy);
      do_req(1'b1, 3'b000, 32'h11, 32'h55, 1'b1, "sb_11", dummy);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, "lw_10_after_sb", dummy);
      do_req(1'b0, 3'b010, 32'h12, 32'h0, 1'b1, "lw_misaligned", dummy);
      do_req(1'b1, 3'b001, 32'h11, 32'hFFFF, 1'b1, "sh_misaligned", dummy);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, "lw_10_unchanged", dummy);
      do_req(1'b0, 3'b010, 32'(DEPTH*4), 32'h0, 1'b1, "lw_out_of_range", dummy);
      do_req(1'b0, 3'b010, 32'(DEPTH*4 - 4), 32'h0, 1'b1, "lw_last_word", dummy);
      do_req(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, "f3_011", dummy);
      do_req(1'b0, 3'b110, 32'h10, 32'h0, 1'b1, "f3_110", dummy);
      do_req(1'b1, 3'b100, 32'h10, 32'h77, 1'b1, "store_f3_100", dummy);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, "lw_10_final", dummy);
      go_idle();
      drain();

      rdy_mode = 2;
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, "lw_hold", dummy);
      go_idle();
      repeat (6) @(negedge i_clk);
      rdy_mode = 0;
      drain();

      do_req(1'b0, 3'b010, 32'h00, 32'h0, 1'b1, "tp0", a0);
      do_req(1'b0, 3'b010, 32'h04, 32'h0, 1'b1, "tp1", a1);
      do_req(1'b0, 3'b010, 32'h08, 32'h0, 1'b1, "tp2", a2);
      do_req(1'b0, 3'b010, 32'h0C, 32'h0, 1'b1, "tp3", a3);
      go_idle();
      chk("throughput 0-1", 32'(a1 - a0), 32'd3);
      chk("throughput 1-2", 32'(a2 - a1), 32'd3);
      chk("throughput 2-3", 32'(a3 - a2), 32'd3);
      drain();

      // Reset during ACCESS: the store must not land.
      do_req(1'b1, 3'b010, 32'h20, 32'h12345678, 1'b0, "sw_20_reset", dummy);
      #1 i_rst = 1'b0;
      #1;
      chk("rst_access rsp_valid", 32'(o_rsp_valid), 32'h0);
      chk("rst_access rsp_rdata", o_rsp_rdata, 32'h0);
      chk("rst_access rsp_err", 32'(o_rsp_err), 32'h0);
      go_idle();
      @(negedge i_clk);
      i_rst = 1'b1;
      do_req(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, "lw_20_after_rst", dummy);
      go_idle();
      drain();

      // Reset during RESP: the response is dropped.
      rdy_mode = 2;
      do_req(1'b0, 3'b010, 32'h04, 32'h0, 1'b1, "lw_rst_resp", dummy);
      go_idle();
      repeat (2) @(negedge i_clk);
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      #1;
      chk("rst_resp rsp_valid", 32'(o_rsp_valid), 32'h0);
      chk("rst_resp rsp_rdata", o_rsp_rdata, 32'h0);
      if (sb.size() != 0) void'(sb.pop_front());
      @(negedge i_clk);
      i_rst = 1'b1;
      rdy_mode = 1;

      for (int k = 0; k < 150; k++) begin
         bit        we;
         bit [2:0]  f3;
         bit [31:0] addr;
         int        sel;
         we  = ($urandom % 3) == 0;
         sel = $urandom_range(0, 19);
         case (sel)
            0:       f3 = 3'b011;
            1:       f3 = 3'b110;
            2:       f3 = 3'b111;
            default: f3 = (sel % 5 == 0) ? 3'b000 : (sel % 5 == 1) ? 3'b001 :
                          (sel % 5 == 2) ? 3'b010 : (sel % 5 == 3) ? 3'b100 : 3'b101;
         endcase
         if ($urandom_range(0, 9) == 0) addr = 32'(DEPTH*4) + 32'($urandom_range(0, 1000));
         else                           addr = 32'($urandom_range(0, 63));
         do_req(we, f3, addr, $urandom, 1'b1, "rand", dummy);
      end
      go_idle();
      rdy_mode = 0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation still running at 500000, expected to finish");
      $fatal(1, "timeout");
   end

endmodule
